// File: rtl/esn_wout_dump.sv
// esn_wout_dump: epoch tracking plus atomic snapshot and 10-word valid/ready dump of readout weights and estimate.
module esn_wout_dump (
  input  logic         clk,
  input  logic         rst_N,
  input  logic [31:0]  est,
  input  logic [255:0] W_out,
  input  logic [5:0]   addr,
  input  logic         req,
  output logic [31:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         dropped
);
  localparam logic S_IDLE = 1'b0;
  localparam logic S_SEND = 1'b1;
  logic         state;
  logic [3:0]   idx;
  logic [15:0]  epoch;
  logic [5:0]   prev_addr;
  logic [255:0] w_snap;
  logic [31:0]  est_snap;
  logic [15:0]  epoch_snap;
  logic [5:0]   addr_snap;
  logic [2:0]   wsel;
  logic [31:0]  word;
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      state      <= S_IDLE;
      idx        <= 4'd0;
      epoch      <= 16'd0;
      prev_addr  <= 6'd0;
      w_snap     <= '0;
      est_snap   <= 32'd0;
      epoch_snap <= 16'd0;
      addr_snap  <= 6'd0;
      dropped    <= 1'b0;
    end else begin
      prev_addr <= addr;
      if (prev_addr == 6'd63 && addr == 6'd0) epoch <= epoch + 16'd1;
      if (state == S_IDLE) begin
        if (req) begin
          state      <= S_SEND;
          idx        <= 4'd0;
          dropped    <= 1'b0;
          w_snap     <= W_out;
          est_snap   <= est;
          epoch_snap <= epoch;
          addr_snap  <= addr;
        end
      end else begin
        if (req) dropped <= 1'b1;
        if (out_ready) begin
          state <= (idx == 4'd9) ? S_IDLE : S_SEND;
          idx   <= (idx == 4'd9) ? 4'd0 : idx + 4'd1;
        end
      end
    end
  end
  // Words 1..8 map to weights 0..7.
  assign wsel = 3'(idx - 4'd1);
  always_comb begin
    word = w_snap[{wsel, 5'b0} +: 32];
    word = (idx == 4'd0) ? {8'hE5, epoch_snap, 2'b00, addr_snap} : (idx == 4'd9) ? est_snap : word;
  end
  assign busy      = state;
  assign out_valid = state;
  assign out_last  = state && idx == 4'd9;
  assign out_data  = state ? word : 32'd0;
endmodule

// File: tb/tb_esn_wout_dump.sv
// tb_esn_wout_dump: randomized and directed checks of esn_wout_dump against a packet-level reference model.
module tb_esn_wout_dump;
  logic         clk, rst_N, req, out_ready;
  logic [31:0]  est;
  logic [255:0] W_out;
  logic [5:0]   addr;
  logic [31:0]  out_data;
  logic         out_valid, out_last, busy, dropped;
  int           n_tests, n_fail;
  logic [31:0]  m_pkt [10];
  logic         m_busy, m_dropped;
  int           m_idx;
  logic [15:0]  m_epoch;
  logic [5:0]   m_prev;

  esn_wout_dump dut (
    .clk(clk), .rst_N(rst_N), .est(est), .W_out(W_out), .addr(addr), .req(req),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .dropped(dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_dropped = 0; m_idx = 0; m_epoch = 0; m_prev = 0;
    for (int i = 0; i < 10; i++) m_pkt[i] = 0;
  endtask

  task automatic cmp();
    chk("valid", 32'(out_valid), 32'(m_busy));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("last", 32'(out_last), 32'(m_busy && m_idx == 9));
    chk("data", out_data, m_busy ? m_pkt[m_idx] : 32'd0);
    chk("dropped", 32'(dropped), 32'(m_dropped));
  endtask

  // Reference behaviour for one rising edge with the current inputs.
  task automatic model_edge();
    if (!m_busy && req) begin
      m_pkt[0] = {8'hE5, m_epoch, 2'b00, addr};
      for (int k = 0; k < 8; k++) m_pkt[k+1] = W_out[32*k +: 32];
      m_pkt[9] = est;
      m_busy = 1; m_idx = 0; m_dropped = 0;
    end else if (m_busy) begin
      if (req) m_dropped = 1;
      if (out_ready) begin
        if (m_idx == 9) m_busy = 0;
        else m_idx++;
      end
    end
    if (m_prev == 6'd63 && addr == 6'd0) m_epoch++;
    m_prev = addr;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    cmp();
  endtask

  task automatic drain();
    req = 0; out_ready = 1;
    repeat (12) tick();
  endtask

  task automatic rand_w();
    for (int k = 0; k < 8; k++) W_out[32*k +: 32] = $urandom;
    est = $urandom;
  endtask

  initial begin
    int nx;
    n_tests = 0; n_fail = 0;
    rst_N = 0; req = 0; out_ready = 0; addr = 0; est = 0; W_out = '0;
    model_reset();
    #3 cmp();
    @(negedge clk); rst_N = 1;
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < 64; a++) begin addr = 6'(a); tick(); end
      addr = 0; tick();
    end
    addr = 5; est = 32'h1234_5678;
    for (int k = 0; k < 8; k++) W_out[32*k +: 32] = 32'h1111_1111 * (k + 1);
    tick();
    req = 1; out_ready = 1; tick(); req = 0;
    chk("hdr3", out_data, 32'hE500_0305);
    repeat (10) tick();
    chk("busy_end", 32'(busy), 32'd0);
    rand_w(); req = 1; tick(); req = 0; nx = 0;
    for (int i = 0; i < 40 && m_busy; i++) begin
      out_ready = (i % 4 == 0 || i % 4 == 3);
      if (out_valid && out_ready) nx++;
      tick();
    end
    chk("xfers", 32'(nx), 32'd10);
    out_ready = 1; rand_w(); req = 1; tick(); req = 0;
    W_out = '1; est = 32'hDEAD_BEEF;
    repeat (10) tick();
    rand_w(); req = 1; tick(); tick();
    chk("drop_w1", 32'(dropped), 32'd1);
    repeat (9) tick();
    chk("gap_busy", 32'(busy), 32'd0);
    tick();
    chk("re_busy", 32'(busy), 32'd1);
    chk("re_drop", 32'(dropped), 32'd0);
    drain();
    addr = 7; rand_w(); req = 1; tick(); req = 0;
    repeat (4) tick();
    #2 rst_N = 0;
    #1 model_reset(); cmp();
    @(negedge clk); rst_N = 1; cmp();
    repeat (3) tick();
    req = 1; tick(); req = 0;
    chk("rst_hdr", out_data, 32'hE500_0007);
    drain();
    addr = 40; tick(); addr = 0; tick();
    req = 1; tick(); req = 0;
    chk("jump_hdr", out_data, 32'hE500_0000);
    drain();
    force dut.epoch = 16'hFFFF;
    #1 release dut.epoch;
    m_epoch = 16'hFFFF;
    addr = 63; tick(); addr = 0; tick();
    addr = 2; req = 1; tick(); req = 0;
    chk("wrap_hdr", out_data, 32'hE500_0002);
    drain();
    for (int i = 0; i < 800; i++) begin
      req = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      addr = ($urandom_range(0, 1) == 0) ? addr + 6'd1 : 6'($urandom);
      if ($urandom_range(0, 2) == 0) rand_w();
      tick();
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
